// File: rtl/watch_pkg.sv
// Shared types, segment codes and BCD field limits for the watch controller.
// Also holds the BCD increment helpers used by time keeping and digit editing.
package watch_pkg;

  typedef enum logic [1:0] {CLK, ALM, SW} mode_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR_MAX   = 8'h23;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam logic [3:0] ONES_MAX = 4'd9;

  // Two-digit BCD counter step, wrapping to zero after top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return '0;
    if (v[3:0] == ONES_MAX)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Single-digit edit on {H1,H0,M1,M0}; no carry between digits.
  function automatic logic [15:0] bump_digit(input logic [15:0] hhmm, input logic [1:0] sel);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = hhmm;
    case (sel)
      2'd0: m0 = (m0 == ONES_MAX) ? '0 : m0 + 4'd1;
      2'd1: m1 = (m1 == TENS_MAX) ? '0 : m1 + 4'd1;
      2'd2: h0 = (h0 == ONES_MAX || (h1 == HR_MAX[7:4] && h0 == HR_MAX[3:0])) ? '0 : h0 + 4'd1;
      default: begin
        h1 = (h1 == HR_MAX[7:4]) ? '0 : h1 + 4'd1;
        if (h1 == HR_MAX[7:4] && h0 > HR_MAX[3:0])
          h0 = HR_MAX[3:0];
      end
    endcase
    return {h1, h0, m1, m0};
  endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// BCD digit to active-high {g,f,e,d,c,b,a} segments; non-BCD codes blank.
module seven_seg_dec
  import watch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/watch_ctrl.sv
// Digital watch controller: 24h clock, armed alarm with beep, MM:SS stopwatch,
// digit-by-digit editing from edge-detected buttons, four 7-seg digit outputs.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50
) (
  input  logic       clk,
  input  logic       resetTime,
  input  logic       modeAlarm,
  input  logic       modeClock,
  input  logic       modeStopWatch,
  input  logic       setValue,
  input  logic       upTime,
  input  logic       nextDigit,
  input  logic       stop,
  output logic [6:0] digit3,
  output logic [6:0] digit2,
  output logic [6:0] digit1,
  output logic [6:0] digit0,
  output logic       alarmBeep
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc, presc_n;
  logic [15:0]   clk_hm, clk_hm_n, alm_hm, alm_hm_n;
  logic [7:0]    sec, sec_n, sw_mm, sw_mm_n, sw_ss, sw_ss_n;
  logic          armed, armed_n, beep_n;
  logic [1:0]    sel, sel_n;
  logic [2:0]    btn_s, btn_p;
  logic          up_p, next_p, set_p, tick, clk_edit;
  logic [15:0]   disp;
  mode_t         mode;

  // modeClock only matters as the default when nothing else is selected.
  always_comb begin
    if (modeStopWatch === 1'b1)   mode = SW;
    else if (modeAlarm === 1'b1)  mode = ALM;
    else                          mode = CLK;
  end

  assign up_p   = btn_s[0] & ~btn_p[0];
  assign next_p = btn_s[1] & ~btn_p[1];
  assign set_p  = btn_s[2] & ~btn_p[2];
  assign tick   = (presc == PRESC_TOP);
  assign clk_edit = (mode == CLK) && (up_p || set_p);

  always_comb begin
    presc_n  = tick ? '0 : presc + 1'b1;
    clk_hm_n = clk_hm;
    sec_n    = sec;
    alm_hm_n = alm_hm;
    armed_n  = armed;
    sel_n    = sel;
    sw_mm_n  = sw_mm;
    sw_ss_n  = sw_ss;

    // An edit landing on a tick keeps the seconds step but drops its carry.
    if (tick) begin
      sec_n = bcd_inc(sec, MIN_MAX);
      if (sec == MIN_MAX && !clk_edit) begin
        clk_hm_n[7:0] = bcd_inc(clk_hm[7:0], MIN_MAX);
        if (clk_hm[7:0] == MIN_MAX)
          clk_hm_n[15:8] = bcd_inc(clk_hm[15:8], HR_MAX);
      end
    end

    if (mode == CLK && set_p) sec_n = '0;
    if (mode == CLK && up_p)  clk_hm_n = bump_digit(clk_hm, sel);
    if (mode == ALM && up_p)  alm_hm_n = bump_digit(alm_hm, sel);
    if (mode == ALM && set_p) armed_n = ~armed;
    if (mode != SW && next_p) sel_n = sel + 2'd1;

    if (mode == SW && set_p && stop) begin
      sw_mm_n = '0;
      sw_ss_n = '0;
    end else if (tick && !stop) begin
      sw_ss_n = bcd_inc(sw_ss, MIN_MAX);
      if (sw_ss == MIN_MAX)
        sw_mm_n = bcd_inc(sw_mm, MIN_MAX);
    end

    beep_n = armed_n && (clk_hm_n == alm_hm_n);
  end

  always_ff @(posedge clk or negedge resetTime) begin
    if (!resetTime) begin
      presc     <= '0;
      clk_hm    <= '0;
      sec       <= '0;
      alm_hm    <= '0;
      armed     <= 1'b0;
      sel       <= '0;
      sw_mm     <= '0;
      sw_ss     <= '0;
      btn_s     <= '0;
      btn_p     <= '0;
      alarmBeep <= 1'b0;
    end else begin
      presc     <= presc_n;
      clk_hm    <= clk_hm_n;
      sec       <= sec_n;
      alm_hm    <= alm_hm_n;
      armed     <= armed_n;
      sel       <= sel_n;
      sw_mm     <= sw_mm_n;
      sw_ss     <= sw_ss_n;
      btn_s     <= {setValue, nextDigit, upTime};
      btn_p     <= btn_s;
      alarmBeep <= beep_n;
    end
  end

  always_comb begin
    case (mode)
      SW:      disp = {sw_mm, sw_ss};
      ALM:     disp = alm_hm;
      default: disp = clk_hm;
    endcase
  end

  seven_seg_dec u_dec3 (.bcd(disp[15:12]), .seg(digit3));
  seven_seg_dec u_dec2 (.bcd(disp[11:8]),  .seg(digit2));
  seven_seg_dec u_dec1 (.bcd(disp[7:4]),   .seg(digit1));
  seven_seg_dec u_dec0 (.bcd(disp[3:0]),   .seg(digit0));

endmodule

// File: tb/tb_watch_ctrl.sv
// Scoreboard bench for watch_ctrl: an integer-time reference model predicts the
// display and beep after every clock edge; a monitor pops and compares.
module tb_watch_ctrl;

  localparam int T = 50;

  logic clk = 1'b0;
  logic resetTime, modeAlarm, modeClock, modeStopWatch;
  logic setValue, upTime, nextDigit, stop;
  logic [6:0] digit3, digit2, digit1, digit0;
  logic alarmBeep;

  watch_ctrl #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .resetTime(resetTime), .modeAlarm(modeAlarm), .modeClock(modeClock),
    .modeStopWatch(modeStopWatch), .setValue(setValue), .upTime(upTime),
    .nextDigit(nextDigit), .stop(stop), .digit3(digit3), .digit2(digit2),
    .digit1(digit1), .digit0(digit0), .alarmBeep(alarmBeep)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] d3, d2, d1, d0;
    logic       beep;
  } obs_t;

  obs_t q[$];
  obs_t mon_exp;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [6:0] segt [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference state: plain integers for time, seconds count for the stopwatch.
  int h, m, s, ah, am, sw, sel, presc, cyc;
  bit armed;
  bit u1, u2, n1, n2, v1, v2;
  bit cur_alm, cur_clk, cur_sw, cur_stop;

  function automatic obs_t make_obs(int a, int b, int c, int d, bit bp);
    obs_t o;
    o.d3 = segt[a]; o.d2 = segt[b]; o.d1 = segt[c]; o.d0 = segt[d]; o.beep = bp;
    return o;
  endfunction

  function automatic obs_t expect_now();
    bit bp = armed && (h == ah) && (m == am);
    if (cur_sw)
      return make_obs((sw / 60) / 10, (sw / 60) % 10, (sw % 60) / 10, (sw % 60) % 10, bp);
    if (cur_alm)
      return make_obs(ah / 10, ah % 10, am / 10, am % 10, bp);
    return make_obs(h / 10, h % 10, m / 10, m % 10, bp);
  endfunction

  function automatic int inc_min(int mm, int which);
    if (which == 0) return (mm / 10) * 10 + ((mm % 10) + 1) % 10;
    if (which == 1) return (((mm / 10) + 1) % 6) * 10 + mm % 10;
    return mm;
  endfunction

  function automatic int inc_hr(int hh, int which);
    int t, o;
    t = hh / 10;
    o = hh % 10;
    if (which == 2) begin
      o = (o + 1) % ((t == 2) ? 4 : 10);
    end else if (which == 3) begin
      t = (t + 1) % 3;
      if (t == 2 && o > 3) o = 3;
    end
    return t * 10 + o;
  endfunction

  task automatic model_reset();
    h = 0; m = 0; s = 0; ah = 0; am = 0; sw = 0; sel = 0; presc = 0; cyc = 0;
    armed = 0; u1 = 0; u2 = 0; n1 = 0; n2 = 0; v1 = 0; v2 = 0;
  endtask

  task automatic model_edge(input bit up, input bit nx, input bit sv);
    bit a_up, a_nx, a_sv, tick, cedit;
    int md;
    a_up  = u1 && !u2;
    a_nx  = n1 && !n2;
    a_sv  = v1 && !v2;
    md    = cur_sw ? 2 : (cur_alm ? 1 : 0);
    tick  = (presc == T - 1);
    cedit = (md == 0) && (a_up || a_sv);
    presc = tick ? 0 : presc + 1;
    if (tick) begin
      s = s + 1;
      if (s == 60) begin
        s = 0;
        if (!cedit) begin
          m = m + 1;
          if (m == 60) begin
            m = 0;
            h = (h + 1) % 24;
          end
        end
      end
    end
    if (md == 0 && a_sv) s = 0;
    if (md == 0 && a_up) begin m = inc_min(m, sel); h = inc_hr(h, sel); end
    if (md == 1 && a_up) begin am = inc_min(am, sel); ah = inc_hr(ah, sel); end
    if (md == 1 && a_sv) armed = !armed;
    if (md != 2 && a_nx) sel = (sel + 1) % 4;
    if (md == 2 && a_sv && cur_stop) sw = 0;
    else if (tick && !cur_stop) sw = (sw + 1) % 3600;
    u2 = u1; u1 = up;
    n2 = n1; n1 = nx;
    v2 = v1; v1 = sv;
    cyc = cyc + 1;
  endtask

  task automatic cmp(input string name, input obs_t e);
    obs_t a;
    a = {digit3, digit2, digit1, digit0, alarmBeep};
    checks = checks + 1;
    if (a !== e) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t got %h %h %h %h beep=%b expected %h %h %h %h beep=%b",
               name, $time, a.d3, a.d2, a.d1, a.d0, a.beep, e.d3, e.d2, e.d1, e.d0, e.beep);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && q.size() > 0) begin
      mon_exp = q.pop_front();
      cmp("scoreboard", mon_exp);
    end
  end

  task automatic step(input bit up, input bit nx, input bit sv);
    @(negedge clk);
    upTime = up; nextDigit = nx; setValue = sv;
    modeAlarm = cur_alm; modeClock = cur_clk; modeStopWatch = cur_sw; stop = cur_stop;
    model_edge(up, nx, sv);
    q.push_back(expect_now());
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int secs);
    while (cyc < secs * T) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_up(input int n);
    repeat (n) begin step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); end
  endtask

  task automatic pulse_nx(input int n);
    repeat (n) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
  endtask

  task automatic pulse_set();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_now(input string name, input int a, input int b, input int c, input int d, input bit bp);
    @(posedge clk);
    #1;
    cmp(name, make_obs(a, b, c, d, bp));
  endtask

  // Asserts reset between edges and checks the outputs before any clock edge.
  task automatic do_reset();
    resetTime = 1'b0;
    upTime = 1'b0; nextDigit = 1'b0; setValue = 1'b0;
    mon_en = 1'b0;
    q.delete();
    model_reset();
    #1;
    cmp("reset_async", make_obs(0, 0, 0, 0, 1'b0));
    repeat (2) @(posedge clk);
    #2;
    resetTime = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    cur_alm = 0; cur_clk = 0; cur_sw = 0; cur_stop = 0;
    modeAlarm = 0; modeClock = 0; modeStopWatch = 0; stop = 0;
    do_reset();

    // Free-running clock with no mode selected: minute boundary.
    while (cyc < 60 * T - 1) step(1'b0, 1'b0, 1'b0);
    chk_now("clock_59s", 0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_now("clock_1min", 0, 0, 0, 1, 1'b0);

    // Clock digit editing and wraps.
    do_reset();
    cur_clk = 1;
    pulse_up(5);
    chk_now("edit_m0", 0, 0, 0, 5, 1'b0);
    pulse_nx(1);
    pulse_up(7);
    chk_now("edit_m1_wrap", 0, 0, 1, 5, 1'b0);
    pulse_nx(2);
    pulse_up(2);
    chk_now("edit_h1_2", 2, 0, 1, 5, 1'b0);
    pulse_up(1);
    chk_now("edit_h1_wrap", 0, 0, 1, 5, 1'b0);
    pulse_nx(3);
    pulse_up(9);
    chk_now("edit_h0_9", 0, 9, 1, 5, 1'b0);
    pulse_nx(1);
    pulse_up(2);
    chk_now("edit_h1_clamp", 2, 3, 1, 5, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_now("held_button_once", 0, 3, 1, 5, 1'b0);

    // Alarm: arm at 00:02, beep for the whole minute, disarm mid-beep.
    do_reset();
    cur_alm = 1;
    pulse_up(2);
    chk_now("alarm_set", 0, 0, 0, 2, 1'b0);
    pulse_set();
    cur_alm = 0;
    run_to(150);
    chk_now("beep_on", 0, 0, 0, 2, 1'b1);
    run_to(181);
    chk_now("beep_off_next_min", 0, 0, 0, 3, 1'b0);
    cur_alm = 1;
    pulse_up(2);
    cur_alm = 0;
    run_to(250);
    chk_now("beep_on_2", 0, 0, 0, 4, 1'b1);
    cur_alm = 1;
    pulse_set();
    chk_now("beep_disarm", 0, 0, 0, 4, 1'b0);
    pulse_set();
    cur_alm = 0;
    run(5);
    chk_now("beep_rearm", 0, 0, 0, 4, 1'b1);
    run(3);
    do_reset();
    run(20);

    // Stopwatch run, hold, clear and ignored clear.
    do_reset();
    cur_sw = 1;
    cur_stop = 0;
    run_to(125);
    chk_now("sw_125s", 0, 2, 0, 5, 1'b0);
    cur_stop = 1;
    run(200);
    chk_now("sw_hold", 0, 2, 0, 5, 1'b0);
    pulse_set();
    chk_now("sw_clear", 0, 0, 0, 0, 1'b0);
    cur_stop = 0;
    run(100);
    pulse_set();
    run(60);
    do_reset();
    run(20);

    // Randomized mixed traffic.
    do_reset();
    cur_alm = 0; cur_clk = 1; cur_sw = 0; cur_stop = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) {cur_sw, cur_alm, cur_clk} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) cur_stop = !cur_stop;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
